// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin sharing of one clocked FP adder among N_REQ requesters, one op in flight.
// Optional FP_ARB_SUB_EN adds req_sub, which flips operand B's sign at grant so the adder yields a-b.
module fp_add_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADD_LAT = 2,
  parameter int ID_W    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [32*N_REQ-1:0] req_op_a,
  input  logic [32*N_REQ-1:0] req_op_b,
`ifdef FP_ARB_SUB_EN
  input  logic [N_REQ-1:0]    req_sub,
`endif
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ID_W-1:0]     rsp_id,
  output logic [31:0]         rsp_sum,
  output logic [31:0]         add_operand_1,
  output logic [31:0]         add_operand_2,
  input  logic [31:0]         add_sum,
  output logic                busy
);
  localparam int CW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t          state_q;
  logic [ID_W-1:0] rr_ptr_q, id_q, rsp_id_q, win, nxt_ptr;
  logic [CW-1:0]   cnt_q;
  logic [31:0]     op1_q, op2_q, rsp_sum_q, win_a, win_b, op2_d;
  logic            rsp_valid_q, found, win_sub;
  logic [N_REQ-1:0] rot;
  // rotate so bit 0 is the requester at rr_ptr; the lowest set bit wins
  always_comb begin
    rot = N_REQ'({req_valid, req_valid} >> rr_ptr_q);
    found = 1'b0;
    win = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (rot[k]) begin
        found = 1'b1;
        win = (int'(rr_ptr_q) + k >= N_REQ) ? ID_W'(int'(rr_ptr_q) + k - N_REQ) : ID_W'(int'(rr_ptr_q) + k);
      end
    win_a = req_op_a[31:0];
    win_b = req_op_b[31:0];
    win_sub = 1'b0;
    for (int k = 0; k < N_REQ; k++)
      if (win == ID_W'(k)) begin
        win_a = req_op_a[32*k +: 32];
        win_b = req_op_b[32*k +: 32];
`ifdef FP_ARB_SUB_EN
        win_sub = req_sub[k];
`endif
      end
    op2_d = win_sub ? {~win_b[31], win_b[30:0]} : win_b;
    nxt_ptr = (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
    req_ready = (state_q == IDLE && found) ? N_REQ'(1) << win : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_id_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (found) begin
          op1_q    <= win_a;
          op2_q    <= op2_d;
          id_q     <= win;
          rr_ptr_q <= nxt_ptr;
          cnt_q    <= CW'(ADD_LAT - 1);
          state_q  <= WAIT;
        end
        WAIT: if (cnt_q == '0) begin
          rsp_sum_q   <= add_sum;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
        RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign rsp_valid     = rsp_valid_q;
  assign rsp_sum       = rsp_sum_q;
  assign rsp_id        = rsp_id_q;
  assign add_operand_1 = op1_q;
  assign add_operand_2 = op2_q;
  assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb_fp_add_arbiter: scoreboard bench with a clocked adder stand-in and a round-robin reference model.
module tb_fp_add_arbiter;
  localparam int N = 4;
  localparam int LAT = 2;
  localparam int IDW = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready, req_sub = '0;
  logic [32*N-1:0] req_op_a = '0, req_op_b = '0;
  logic rsp_valid, rsp_ready = 1'b1, busy;
  logic [IDW-1:0] rsp_id;
  logic [31:0] rsp_sum, add_operand_1, add_operand_2, add_sum, sum_q;
  int checks = 0, errors = 0;
  typedef struct {int id; logic [31:0] sum;} exp_t;
  exp_t sb[$];
  int glog[$];
  int ptr = 0, g = 0;
  bit inflt = 0;
  logic [31:0] e_op1, e_op2;

  fp_add_arbiter #(.N_REQ(N), .ADD_LAT(LAT), .ID_W(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op_a(req_op_a), .req_op_b(req_op_b),
`ifdef FP_ARB_SUB_EN
    .req_sub(req_sub),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .add_operand_1(add_operand_1), .add_operand_2(add_operand_2), .add_sum(add_sum), .busy(busy));

  always #5 clk = ~clk;

  // adder stand-in: known IEEE sums for the directed vectors, an arbitrary mix otherwise
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3FC00000 && b == 32'h415B0000) return 32'h41730000;
    if (a == 32'h3F180000 && b == 32'h415B0000) return 32'h41648000;
    if (a == 32'h415B0000 && b == 32'hBFC00000) return 32'h41430000;
    return (a ^ {b[15:0], b[31:16]}) + 32'h9E3779B9;
  endfunction
  always_ff @(posedge clk) sum_q <= fadd(add_operand_1, add_operand_2);
  assign add_sum = sum_q;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int w;
    bit gnt;
    logic [N-1:0] er;
    logic [31:0] aa, bb;
    if (!rst_n) begin
      inflt = 0; ptr = 0; g = 0; sb.delete();
    end else begin
      if (inflt) g++;
      w = -1;
      for (int k = 0; k < N; k++) if (w < 0 && req_valid[(ptr + k) % N]) w = (ptr + k) % N;
      gnt = !inflt && w >= 0;
      er = gnt ? N'(1) << w : '0;
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("busy", 32'(busy), 32'(inflt));
      chk("rsp_valid", 32'(rsp_valid), 32'(inflt && g > LAT));
      if (inflt) begin
        chk("add_operand_1", add_operand_1, e_op1);
        chk("add_operand_2", add_operand_2, e_op2);
      end
      if (rsp_valid) begin
        if (sb.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        else begin
          chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
          chk("rsp_sum", rsp_sum, sb[0].sum);
          if (rsp_ready) begin void'(sb.pop_front()); inflt = 0; end
        end
      end
      if (gnt) begin
        aa = req_op_a[32*w +: 32];
        bb = req_op_b[32*w +: 32];
        if (req_sub[w]) bb[31] = ~bb[31];
        sb.push_back('{w, fadd(aa, bb)});
        e_op1 = aa; e_op2 = bb;
        glog.push_back(w);
        ptr = (w + 1) % N; inflt = 1; g = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic wait_idle();
    int i = 0;
    while ((busy || rsp_valid) && i < 100) begin tick(); i++; end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask
  task automatic wait_rsp();
    int i = 0;
    while (!rsp_valid && i < 50) begin tick(); i++; end
    chk("rsp_timeout", 32'(rsp_valid), 32'd1);
  endtask
  task automatic outs_zero(input string nm);
    chk({nm, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({nm, "_op1"}, add_operand_1, 32'd0);
    chk({nm, "_op2"}, add_operand_2, 32'd0);
    chk({nm, "_rsp_sum"}, rsp_sum, 32'd0);
    chk({nm, "_rsp_id"}, 32'(rsp_id), 32'd0);
  endtask
  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_op_a[32*i +: 32] = a;
    req_op_b[32*i +: 32] = b;
  endtask

  initial begin
    int c, seen;
    repeat (3) tick();
    outs_zero("reset");
    rst_n = 1'b1;
    tick();
    // reset in the middle of WAIT
    set_op(1, 32'h12345678, 32'h9ABCDEF0);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    chk("t1_busy", 32'(busy), 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    outs_zero("t1_async");
    tick(); tick();
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin tick(); seen += rsp_valid; end
    chk("t1_no_rsp", 32'(seen), 32'd0);
    // all four held: grants start at 0 and wrap
    glog.delete();
    req_valid = 4'b1111;
    c = 0;
    while (glog.size() < 5 && c < 100) begin
      for (int i = 0; i < N; i++) set_op(i, $urandom, $urandom);
      tick(); c++;
    end
    req_valid = '0;
    chk("t3_grants", 32'(glog.size()), 32'd5);
    for (int i = 0; i < 5 && i < glog.size(); i++) chk("t3_order", 32'(glog[i]), 32'(i % N));
    wait_idle();
    // single add, latency from request to response
    set_op(0, 32'h3FC00000, 32'h415B0000);
    req_valid = 4'b0001;
    c = 0;
    while (!rsp_valid && c < 20) begin tick(); c++; if (c == 1) req_valid = '0; end
    chk("t2_latency", 32'(c), 32'(LAT + 1));
    chk("t2_sum", rsp_sum, 32'h41730000);
    chk("t2_id", 32'(rsp_id), 32'd0);
    wait_idle();
    // backpressure holds the response; pending request waits
    rsp_ready = 1'b0;
    set_op(2, 32'h3F180000, 32'h415B0000);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    wait_rsp();
    set_op(0, $urandom, $urandom);
    req_valid = 4'b0001;
    repeat (5) begin
      tick();
      chk("t4_valid", 32'(rsp_valid), 32'd1);
      chk("t4_sum", rsp_sum, 32'h41648000);
      chk("t4_id", 32'(rsp_id), 32'd2);
      chk("t4_no_grant", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("t4_idle", 32'(busy), 32'd0);
    chk("t4_grant0", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    wait_idle();
    // a request dropped while busy is never granted
    set_op(3, $urandom, $urandom);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    glog.delete();
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    wait_idle();
    repeat (3) tick();
    chk("t5_no_grant", 32'(glog.size()), 32'd0);
`ifdef FP_ARB_SUB_EN
    req_sub = 4'b0001;
    set_op(0, 32'h415B0000, 32'h3FC00000);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    chk("t6_op2", add_operand_2, 32'hBFC00000);
    wait_rsp();
    chk("t6_sum", rsp_sum, 32'h41430000);
    wait_idle();
    req_sub = '0;
`endif
    // random traffic
    repeat (400) begin
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) set_op(i, $urandom, $urandom);
      rsp_ready = 1'($urandom);
`ifdef FP_ARB_SUB_EN
      req_sub = N'($urandom);
`endif
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle();
    repeat (2) tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
